// File: rtl/aes_round_sequencer_if.sv
// Bus bundle between the AES round sequencer and its environment: block handshake,
// result handshake, key-store lookup and the shared round-datapath port.
interface aes_round_sequencer_if #(
  parameter int unsigned NB_BLOCK = 128,
  parameter int unsigned NB_ROUND = 4
);
  logic                i_valid;
  logic [NB_BLOCK-1:0] i_state;
  logic [NB_BLOCK-1:0] i_data;
  logic                o_ready;

  logic                o_valid;
  logic [NB_BLOCK-1:0] o_state;
  logic [NB_BLOCK-1:0] o_data;
  logic                i_ready;

  logic [NB_ROUND-1:0] o_key_index;
  logic [NB_BLOCK-1:0] i_round_key;

  logic [NB_BLOCK-1:0] o_rb_state;
  logic [NB_BLOCK-1:0] o_rb_round_key;
  logic [NB_ROUND-1:0] o_rb_round_index;
  logic                o_rb_valid;
  logic [NB_BLOCK-1:0] i_rb_state;
  logic                i_rb_valid;

  logic                o_busy;
  logic                o_error;

  modport master (
    input  i_valid, i_state, i_data, i_ready, i_round_key, i_rb_state, i_rb_valid,
    output o_ready, o_valid, o_state, o_data, o_key_index,
           o_rb_state, o_rb_round_key, o_rb_round_index, o_rb_valid, o_busy, o_error
  );

  modport slave (
    output i_valid, i_state, i_data, i_ready, i_round_key, i_rb_state, i_rb_valid,
    input  o_ready, o_valid, o_state, o_data, o_key_index,
           o_rb_state, o_rb_round_key, o_rb_round_index, o_rb_valid, o_busy, o_error
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES controller: runs one block through a shared round datapath, one round at a time.
// Optional macro AES_ROUND_SEQ_WATCHDOG_EN adds a sticky timeout on the round-datapath return.
module aes_round_sequencer #(
  parameter int unsigned NB_BYTE           = 8,
  parameter int unsigned N_BYTES           = 16,
  parameter int unsigned FIRST_ROUND_INDEX = 0,
  parameter int unsigned LAST_ROUND_INDEX  = 14,
  parameter int unsigned NB_ROUND          = 4,
  parameter int unsigned ROUND_LATENCY     = 1
) (
  input logic                   i_clock,
  input logic                   i_reset,
  aes_round_sequencer_if.master bus
);
  localparam int unsigned NB_BLOCK = NB_BYTE * N_BYTES;
  localparam logic [NB_ROUND-1:0] FIRST_RND = NB_ROUND'(FIRST_ROUND_INDEX);
  localparam logic [NB_ROUND-1:0] LAST_RND  = NB_ROUND'(LAST_ROUND_INDEX);

  if ((ROUND_LATENCY < 1) || (ROUND_LATENCY > 3)) begin : g_bad_latency
    $error("ROUND_LATENCY must be within 1..3");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [NB_BLOCK-1:0] state_q, state_d;
  logic [NB_BLOCK-1:0] data_q, data_d;
  logic [NB_ROUND-1:0] round_q, round_d;
  logic                ready_en_q, ready_en_d;

  logic ready_c, valid_c, busy_c, rb_valid_c;
  logic accept, rb_take, last_round, timeout;

  assign accept     = bus.i_valid && ready_c;
  assign last_round = (round_q == LAST_RND);
  assign rb_take    = (fsm_q == ST_WAIT) && bus.i_rb_valid;

`ifdef AES_ROUND_SEQ_WATCHDOG_EN
  localparam int unsigned   WD_W    = 3;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(ROUND_LATENCY + 3);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;

  // Counts WAIT cycles without a return; the last allowed cycle is ROUND_LATENCY+4.
  assign timeout = (fsm_q == ST_WAIT) && !bus.i_rb_valid && (wd_q == WD_LAST);

  always_comb begin
    wd_d    = wd_q;
    error_d = error_q;
    if (fsm_q == ST_ISSUE) begin
      wd_d = '0;
    end else if ((fsm_q == ST_WAIT) && !bus.i_rb_valid) begin
      wd_d = wd_q + 1'b1;
    end
    if (timeout) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign bus.o_error = error_q;
`else
  assign timeout     = 1'b0;
  assign bus.o_error = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next state
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (accept) fsm_d = ST_ISSUE;
      ST_ISSUE: fsm_d = ST_WAIT;
      ST_WAIT: begin
        if (timeout) begin
          fsm_d = ST_IDLE;
        end else if (bus.i_rb_valid) begin
          fsm_d = last_round ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE:  if (bus.i_ready) fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  // FSM outputs; o_ready stays low until the first edge after reset release
  always_comb begin
    ready_c    = 1'b0;
    valid_c    = 1'b0;
    busy_c     = 1'b1;
    rb_valid_c = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        ready_c = ready_en_q;
        busy_c  = 1'b0;
      end
      ST_ISSUE: rb_valid_c = 1'b1;
      ST_WAIT:  ;
      ST_DONE:  valid_c = 1'b1;
      default:  ;
    endcase
  end

  // Block, sideband and round-counter updates
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    round_d    = round_q;
    ready_en_d = 1'b1;
    if (accept) begin
      state_d = bus.i_state;
      data_d  = bus.i_data;
      round_d = FIRST_RND;
    end else if (rb_take) begin
      state_d = bus.i_rb_state;
      if (!last_round) begin
        round_d = round_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= '0;
      data_q     <= '0;
      round_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      round_q    <= round_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign bus.o_ready          = ready_c;
  assign bus.o_valid          = valid_c;
  assign bus.o_busy           = busy_c;
  assign bus.o_state          = state_q;
  assign bus.o_data           = data_q;
  assign bus.o_key_index      = round_q;
  assign bus.o_rb_valid       = rb_valid_c;
  assign bus.o_rb_state       = state_q;
  assign bus.o_rb_round_index = round_q;
  // Key is combinational from the store; gate it so it is only seen during the issue strobe
  assign bus.o_rb_round_key   = rb_valid_c ? bus.i_round_key : '0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: AES-256 key store and round datapath model,
// scoreboard of expected ciphertext/sideband, timing, backpressure, reset and watchdog cases.
module tb_aes_round_sequencer;
  localparam int unsigned NB_BLOCK = 128;
  localparam int unsigned NB_ROUND = 4;
  localparam int          LAT      = 31;
  localparam int          PERIOD   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_sequencer_if #(.NB_BLOCK(NB_BLOCK), .NB_ROUND(NB_ROUND)) bus ();

  aes_round_sequencer dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic [127:0] st;
    logic [127:0] dt;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  logic [7:0]   sbt [256];
  logic [127:0] rk  [16];
  logic         mute = 1'b0;
  logic         spur = 1'b0;
  logic [127:0] spur_state = '0;
  logic         rb_valid_m;
  logic [127:0] rb_state_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  // One AES round: 0 = AddRoundKey only, 14 = no MixColumns
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input int r);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = s[8*(15-i) +: 8];
    if (r != 0) begin
      for (int i = 0; i < 16; i++) a[i] = sbt[a[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) b[j+4*c] = a[j + 4*((c+j)%4)];
      for (int c = 0; c < 4; c++) begin
        if (r != 14) begin
          a[4*c]   = xtime(b[4*c]) ^ xtime(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
          a[4*c+1] = b[4*c] ^ xtime(b[4*c+1]) ^ xtime(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
          a[4*c+2] = b[4*c] ^ b[4*c+1] ^ xtime(b[4*c+2]) ^ xtime(b[4*c+3]) ^ b[4*c+3];
          a[4*c+3] = xtime(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xtime(b[4*c+3]);
        end else begin
          for (int j = 0; j < 4; j++) a[4*c+j] = b[4*c+j];
        end
      end
    end
    for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = a[i];
    return o ^ k;
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt);
    logic [127:0] s;
    s = pt;
    for (int r = 0; r < 15; r++) s = aes_round(s, rk[r], r);
    return s;
  endfunction

  task automatic build_tables(input logic [255:0] key);
    logic [7:0]  inv, x, rc;
    logic [31:0] w [60];
    logic [31:0] t;
    for (int v = 0; v < 256; v++) begin
      x   = 8'(v);
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, x);
      sbt[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int i = 0; i < 8; i++) w[i] = key[32*(7-i) +: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = subword(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk[15] = '0;
  endtask

  // Key store and L=1 round datapath
  assign bus.i_round_key = rk[bus.o_key_index];
  assign bus.i_rb_valid  = rb_valid_m | spur;
  assign bus.i_rb_state  = spur ? spur_state : rb_state_m;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_valid_m <= 1'b0;
      rb_state_m <= '0;
    end else begin
      rb_valid_m <= bus.o_rb_valid && !mute;
      if (bus.o_rb_valid)
        rb_state_m <= aes_round(bus.o_rb_state, bus.o_rb_round_key, int'(bus.o_rb_round_index));
    end
  end

  // Monitor: issue strobes, latency and scoreboard pops
  int   exp_idx = 0;
  int   strobes = 0;
  int   acc_cyc = 0;
  bit   inflight = 1'b0;
  bit   prev_rbv = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (rst) begin
      exp_idx  = 0;
      strobes  = 0;
      inflight = 1'b0;
      prev_rbv = 1'b0;
    end else begin
      if (bus.o_rb_valid) begin
        chk("rb_single", 128'(prev_rbv), 128'(0));
        chk("rb_index", 128'(bus.o_rb_round_index), 128'(exp_idx));
        chk("key_index", 128'(bus.o_key_index), 128'(exp_idx));
        chk("rb_key", bus.o_rb_round_key, rk[4'(exp_idx)]);
        exp_idx++;
        strobes++;
      end
      prev_rbv = bus.o_rb_valid;
      if (bus.o_valid && inflight) begin
        chk("latency", 128'(cyc - acc_cyc), 128'(LAT));
        chk("strobe_count", 128'(strobes), 128'(15));
        inflight = 1'b0;
      end
      if (bus.o_valid && bus.i_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_valid", 128'(1), 128'(0));
        end else begin
          e = sb_q.pop_front();
          chk("o_state", bus.o_state, e.st);
          chk("o_data", bus.o_data, e.dt);
        end
      end
      if (bus.i_valid && bus.o_ready) begin
        acc_cyc  = cyc;
        inflight = 1'b1;
        exp_idx  = 0;
        strobes  = 0;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 128'({bus.o_ready, bus.o_valid, bus.o_busy, bus.o_error, bus.o_rb_valid,
                             bus.o_key_index, bus.o_rb_round_index}), 128'(0));
    chk({tag, "_ostate"}, bus.o_state, '0);
    chk({tag, "_odata"}, bus.o_data, '0);
    chk({tag, "_rbstate"}, bus.o_rb_state, '0);
    chk({tag, "_rbkey"}, bus.o_rb_round_key, '0);
  endtask

  task automatic send(input logic [127:0] pt, input logic [127:0] dt, input logic [127:0] ct,
                      input bit push, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    @(posedge clk); #1;
    bus.i_valid = 1'b1;
    bus.i_state = pt;
    bus.i_data  = dt;
    if (push) sb_q.push_back('{st: ct, dt: dt});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = bus.o_ready;
      acc = cyc;
      @(posedge clk); #1;
      if (got) break;
    end
    bus.i_valid = 1'b0;
    if (!got) chk("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_issue(input int idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.o_rb_valid && (int'(bus.o_rb_round_index) == idx);
    end
    if (!seen) chk("issue_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain", 128'(sb_q.size()), 128'(0));
  endtask

  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] SIDE    = {16{8'hA5}};

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int           acc_a, acc_b;
    bit           seen;
    logic [127:0] pt, dt, ct;
    bus.i_valid = 1'b0;
    bus.i_state = '0;
    bus.i_data  = '0;
    bus.i_ready = 1'b1;
    build_tables(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", 128'(bus.o_ready), 128'(0));
    @(negedge clk);
    chk("ready_after_edge", 128'(bus.o_ready), 128'(1));

    // FIPS-197 AES-256 vector
    send(FIPS_PT, SIDE, FIPS_CT, 1'b1, acc_a);
    wait_drain();

    // Spurious return while idle
    @(posedge clk); #1;
    spur = 1'b1;
    spur_state = 128'hdeadbeef_00000000_cafef00d_12345678;
    @(posedge clk); #1;
    spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", 128'(bus.o_busy), 128'(0));
    chk("spur_idle_state", bus.o_state, FIPS_CT);

    // Backpressure with a spurious return during DONE
    bus.i_ready = 1'b0;
    pt = {$urandom, $urandom, $urandom, $urandom};
    dt = {$urandom, $urandom, $urandom, $urandom};
    ct = aes_enc(pt);
    send(pt, dt, ct, 1'b1, acc_a);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = bus.o_valid;
    end
    chk("bp_valid_seen", 128'(seen), 128'(1));
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 128'(bus.o_valid), 128'(1));
      chk("bp_state", bus.o_state, ct);
      chk("bp_data", bus.o_data, dt);
      chk("bp_ready", 128'(bus.o_ready), 128'(0));
      chk("bp_rbv", 128'(bus.o_rb_valid), 128'(0));
      @(posedge clk); #1;
      spur = (i == 3);
      if (i == 9) bus.i_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_last_valid", 128'(bus.o_valid), 128'(1));
    chk("bp_last_ready", 128'(bus.o_ready), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_ready", 128'(bus.o_ready), 128'(1));
    chk("bp_release_valid", 128'(bus.o_valid), 128'(0));

    // Back-to-back blocks: one block per N(L+1)+2 cycles
    pt = {$urandom, $urandom, $urandom, $urandom};
    dt = {$urandom, $urandom, $urandom, $urandom};
    send(pt, dt, aes_enc(pt), 1'b1, acc_a);
    pt = {$urandom, $urandom, $urandom, $urandom};
    dt = {$urandom, $urandom, $urandom, $urandom};
    send(pt, dt, aes_enc(pt), 1'b1, acc_b);
    chk("throughput", 128'(acc_b - acc_a), 128'(PERIOD));
    wait_drain();

    // Reset during the round-7 WAIT drops the block
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(pt, SIDE, '0, 1'b0, acc_a);
    wait_issue(7);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    send(FIPS_PT, SIDE, FIPS_CT, 1'b1, acc_a);
    wait_drain();

    // Missing round return after round 3
    pt = {$urandom, $urandom, $urandom, $urandom};
    send(pt, SIDE, '0, 1'b0, acc_a);
    wait_issue(3);
    mute = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("wd_wait_busy", 128'(bus.o_busy), 128'(1));
      chk("wd_wait_err", 128'(bus.o_error), 128'(0));
    end
    @(negedge clk);
`ifdef AES_ROUND_SEQ_WATCHDOG_EN
    chk("wd_error", 128'(bus.o_error), 128'(1));
    chk("wd_idle", 128'(bus.o_busy), 128'(0));
    chk("wd_ready", 128'(bus.o_ready), 128'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_sticky", 128'(bus.o_error), 128'(1));
      chk("wd_no_valid", 128'(bus.o_valid), 128'(0));
    end
`else
    chk("wd_error", 128'(bus.o_error), 128'(0));
    chk("wd_stuck", 128'(bus.o_busy), 128'(1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wd_still_busy", 128'(bus.o_busy), 128'(1));
      chk("wd_no_valid", 128'(bus.o_valid), 128'(0));
    end
`endif
    @(posedge clk); #1;
    rst  = 1'b1;
    mute = 1'b0;
    #1;
    chk("wd_reset_err", 128'(bus.o_error), 128'(0));
    chk("wd_reset_busy", 128'(bus.o_busy), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_left", 128'(sb_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
